// File: rtl/bcd_key_scheduler_if.sv
// Signal bundle between bcd_key_scheduler, its raw key lines, the shared
// one-hot-to-BCD encoder and the downstream digit consumer.
interface bcd_key_scheduler_if;
    logic [9:0] req;
    logic [9:0] enc_in;
    logic       enc_en;
    logic [3:0] enc_out;
    logic [3:0] digit;
    logic       digit_valid;
    logic       digit_ready;
    logic       busy;
    logic       enc_err;

    modport master (
        input  req,
        input  enc_out,
        input  digit_ready,
        output enc_in,
        output enc_en,
        output digit,
        output digit_valid,
        output busy,
        output enc_err
    );

    modport slave (
        output req,
        output enc_out,
        output digit_ready,
        input  enc_in,
        input  enc_en,
        input  digit,
        input  digit_valid,
        input  busy,
        input  enc_err
    );
endinterface

// File: rtl/bcd_key_scheduler.sv
// Debounced round-robin sequencer for a shared one-hot-to-BCD encoder over 10 key lines.
// Build macro BCD_KEY_SCHED_CHECK_EN adds a sticky encoder self-check on enc_err.
module bcd_key_scheduler #(
    parameter int STABLE_CYC = 3,
    parameter int CNT_W      = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_key_scheduler_if.master bus
);
    localparam int N = 10;
    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] hi_cnt [N];
    logic [CNT_W-1:0] lo_cnt [N];
    logic [N-1:0]     armed;
    logic [N-1:0]     pending;
    logic [3:0]       rr_ptr;
    logic [3:0]       grant_k;
    logic [3:0]       pick_k;
    logic             pick_vld;
    logic             grant_fire;

    function automatic logic [3:0] wrap_idx(input logic [3:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return s[3:0];
    endfunction

    // Round-robin pick: first pending line at or after rr_ptr, wrapping 9 -> 0.
    always_comb begin
        pick_vld = 1'b0;
        pick_k   = 4'd0;
        for (int off = 0; off < N; off++) begin
            if (!pick_vld && pending[wrap_idx(rr_ptr, off)]) begin
                pick_vld = 1'b1;
                pick_k   = wrap_idx(rr_ptr, off);
            end
        end
    end

    assign grant_fire = (state == IDLE) && pick_vld;

    // Per-line filter: a press must be stable STABLE_CYC samples to pend, and the
    // line must be released STABLE_CYC samples before it can pend again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                hi_cnt[i] <= '0;
                lo_cnt[i] <= '0;
            end
            armed   <= '1;
            pending <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (bus.req[i]) begin
                    lo_cnt[i] <= '0;
                    if (hi_cnt[i] != STABLE) hi_cnt[i] <= hi_cnt[i] + CNT_W'(1);
                end else begin
                    hi_cnt[i] <= '0;
                    if (lo_cnt[i] != STABLE) lo_cnt[i] <= lo_cnt[i] + CNT_W'(1);
                end
                // A grant of this line overrides any set in the same cycle.
                if (grant_fire && (pick_k == 4'(i))) begin
                    pending[i] <= 1'b0;
                    armed[i]   <= 1'b0;
                end else begin
                    if ((hi_cnt[i] == STABLE) && armed[i]) pending[i] <= 1'b1;
                    if (lo_cnt[i] == STABLE) armed[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_vld) state_next = ENC;
            ENC:     state_next = OUT;
            OUT:     if (bus.digit_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Encoder drive is decoded from state so an async reset clears it at once.
    always_comb begin
        bus.enc_en = 1'b0;
        bus.enc_in = '0;
        bus.busy   = (state != IDLE);
        if (state == ENC) begin
            bus.enc_en = 1'b1;
            bus.enc_in = N'(1) << grant_k;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr          <= 4'd0;
            grant_k         <= 4'd0;
            bus.digit       <= 4'd0;
            bus.digit_valid <= 1'b0;
        end else begin
            if (grant_fire) begin
                grant_k <= pick_k;
                rr_ptr  <= (pick_k == 4'd9) ? 4'd0 : pick_k + 4'd1;
            end
            if (state == ENC) begin
                bus.digit       <= bus.enc_out;
                bus.digit_valid <= 1'b1;
            end else if ((state == OUT) && bus.digit_ready) begin
                bus.digit_valid <= 1'b0;
            end
        end
    end

`ifdef BCD_KEY_SCHED_CHECK_EN
    logic enc_err_q;

    // For a decimal index the BCD code equals the binary index itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_err_q <= 1'b0;
        end else if ((state == ENC) && (bus.enc_out != grant_k)) begin
            enc_err_q <= 1'b1;
        end
    end

    assign bus.enc_err = enc_err_q;
`else
    assign bus.enc_err = 1'b0;
`endif

endmodule
